// File: rtl/ram2_ctrl_pkg.sv
// rtl/ram2_ctrl_pkg.sv - shared state encoding, strobe levels and bus widths for ram2_ctrl
package ram2_ctrl_pkg;

  // Pipeline-side bus widths
  localparam int DATA_BUS_W      = 32;
  localparam int INST_BUS_W      = 32;
  localparam int DATA_ADDR_BUS_W = 32;

  // Active levels of the SRAM strobes
  localparam logic RAM_CHIP_ENABLE = 1'b0;
  localparam logic WRITE_ENABLE    = 1'b0;

  typedef enum logic [2:0] {
    RAM2_IDLE     = 3'd0,
    RAM2_RD_I     = 3'd1,
    RAM2_RD_D     = 3'd2,
    RAM2_WR_SETUP = 3'd3,
    RAM2_WR_PULSE = 3'd4,
    RAM2_WR_HOLD  = 3'd5
  } ram2_state_t;

  // Access accepted in IDLE and waiting to be launched on the next edge
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_FETCH = 2'd1,
    ACC_READ  = 2'd2,
    ACC_WRITE = 2'd3
  } acc_kind_t;

  // First sequencing state of an accepted access
  function automatic ram2_state_t kind_to_state(acc_kind_t kind);
    case (kind)
      ACC_FETCH: return RAM2_RD_I;
      ACC_READ:  return RAM2_RD_D;
      ACC_WRITE: return RAM2_WR_SETUP;
      default:   return RAM2_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ram2_ctrl_if.sv
// rtl/ram2_ctrl_if.sv - pipeline and SRAM signal bundle of ram2_ctrl
interface ram2_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  import ram2_ctrl_pkg::*;

  // Instruction-fetch port
  logic                       if_req;
  logic [DATA_ADDR_BUS_W-1:0] if_addr;
  logic [DATA_W-1:0]          inst;
  logic                       inst_valid;

  // MEM-stage data port
  logic                       mem_re;
  logic                       mem_we;
  logic [DATA_ADDR_BUS_W-1:0] mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [DATA_W-1:0]          mem_rdata;
  logic                       mem_done;
  logic                       stall_req;

  // External word SRAM
  logic [ADDR_W-1:0]          ram_addr;
  logic [DATA_W-1:0]          ram_wdata;
  logic [DATA_W-1:0]          ram_rdata;
  logic                       ram_data_oe;
  logic                       ram_ce_n;
  logic                       ram_oe_n;
  logic                       ram_we_n;

  // Controller view
  modport slave (
    input  if_req, if_addr, mem_re, mem_we, mem_addr, mem_wdata, ram_rdata,
    output inst, inst_valid, mem_rdata, mem_done, stall_req,
           ram_addr, ram_wdata, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n
  );

  // Pipeline plus SRAM view
  modport master (
    output if_req, if_addr, mem_re, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  inst, inst_valid, mem_rdata, mem_done, stall_req,
           ram_addr, ram_wdata, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n
  );

endinterface

// File: rtl/ram2_ctrl.sv
// rtl/ram2_ctrl.sv - fetch/data arbiter and strobe sequencer for the RAM2 word SRAM
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int WR_CYCLES = 1
) (
  input logic         clk,
  input logic         rst,
  ram2_ctrl_if.slave  bus
);

  localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  ram2_state_t       state;
  acc_kind_t         pend;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic              data_oe;
  logic [DATA_W-1:0] inst_q;
  logic              inst_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;

  // A request still held high during its own completion pulse must not be taken again
  logic data_ok;
  logic fetch_ok;
  assign data_ok  = ~done_q;
  assign fetch_ok = ~inst_valid_q;

  // Only the low word-address bits reach the SRAM
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[DATA_ADDR_BUS_W-1:ADDR_W],
                              bus.mem_addr[DATA_ADDR_BUS_W-1:ADDR_W]};

  // Arbitration, latching and strobe sequencing; every strobe is a register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RAM2_IDLE;
      pend         <= ACC_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      ce_n         <= ~RAM_CHIP_ENABLE;
      oe_n         <= 1'b1;
      we_n         <= ~WRITE_ENABLE;
      data_oe      <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        RAM2_IDLE: begin
          if (pend != ACC_NONE) begin
            state   <= kind_to_state(pend);
            pend    <= ACC_NONE;
            ce_n    <= RAM_CHIP_ENABLE;
            oe_n    <= (pend == ACC_WRITE);
            data_oe <= (pend == ACC_WRITE);
          end else if (data_ok && bus.mem_we) begin
            pend    <= ACC_WRITE;
            addr_q  <= bus.mem_addr[ADDR_W-1:0];
            wdata_q <= bus.mem_wdata;
          end else if (data_ok && bus.mem_re) begin
            pend    <= ACC_READ;
            addr_q  <= bus.mem_addr[ADDR_W-1:0];
          end else if (fetch_ok && bus.if_req) begin
            pend    <= ACC_FETCH;
            addr_q  <= bus.if_addr[ADDR_W-1:0];
          end
        end
        RAM2_RD_I: begin
          inst_q       <= bus.ram_rdata;
          inst_valid_q <= 1'b1;
          state        <= RAM2_IDLE;
          ce_n         <= ~RAM_CHIP_ENABLE;
          oe_n         <= 1'b1;
        end
        RAM2_RD_D: begin
          rdata_q <= bus.ram_rdata;
          done_q  <= 1'b1;
          state   <= RAM2_IDLE;
          ce_n    <= ~RAM_CHIP_ENABLE;
          oe_n    <= 1'b1;
        end
        RAM2_WR_SETUP: begin
          state <= RAM2_WR_PULSE;
          we_n  <= WRITE_ENABLE;
          cnt   <= CNT_W'(WR_CYCLES - 1);
        end
        RAM2_WR_PULSE: begin
          if (cnt == '0) begin
            state <= RAM2_WR_HOLD;
            we_n  <= ~WRITE_ENABLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RAM2_WR_HOLD: begin
          state   <= RAM2_IDLE;
          done_q  <= 1'b1;
          ce_n    <= ~RAM_CHIP_ENABLE;
          data_oe <= 1'b0;
        end
        default: begin
          state   <= RAM2_IDLE;
          pend    <= ACC_NONE;
          ce_n    <= ~RAM_CHIP_ENABLE;
          oe_n    <= 1'b1;
          we_n    <= ~WRITE_ENABLE;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_req   = rst & (((bus.mem_re | bus.mem_we) & ~done_q) |
                                  (bus.if_req & ~inst_valid_q));
  assign bus.inst        = inst_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.mem_done    = done_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.ram_data_oe = data_oe;
  assign bus.ram_ce_n    = ce_n;
  assign bus.ram_oe_n    = oe_n;
  assign bus.ram_we_n    = we_n;

endmodule

// File: tb/tb_ram2_ctrl.sv
// tb/tb_ram2_ctrl.sv - randomized self-checking bench for ram2_ctrl against a transaction-level model
module tb_ram2_ctrl;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 32;
  localparam int WRC     = 3;
  localparam int K_FETCH = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram2_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram2_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WRC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // SRAM device contents and the model's view of memory
  logic [31:0] sram    [0:63];
  logic [31:0] ref_mem [0:63];
  bit          inited = 1'b0;

  assign bus.ram_rdata = (!bus.ram_ce_n && !bus.ram_oe_n) ? sram[bus.ram_addr[5:0]] : 32'h0;

  // Model: accesses are whole transactions with a start edge and a fixed completion edge
  int          cyc = 0;
  bit          busy = 1'b0;
  int          acc_s = 0;
  int          acc_end = 0;
  int          acc_kind = 0;
  logic [31:0] acc_addr = '0;
  logic [31:0] acc_data = '0;
  int          end_fetch = -100;
  int          end_data = -100;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_mrd = '0;

  // Driver state: 0 none, 1 requesting, 2 holding one cycle past completion
  int f_st = 0;
  int d_st = 0;
  bit rnd = 1'b0;
  bit force_hold = 1'b0;
  bit scramble = 1'b0;

  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 64; i++) begin
        ref_mem[i] = $urandom;
        sram[i]    = ref_mem[i];
      end
      ref_mem[5] = 32'h1111_0005;    sram[5] = 32'h1111_0005;
      ref_mem[6] = 32'h2222_0006;    sram[6] = 32'h2222_0006;
      ref_mem[16] = 32'h3C01_8000;   sram[16] = 32'h3C01_8000;
      inited = 1'b1;
    end
    if (!bus.ram_ce_n && !bus.ram_we_n && bus.ram_data_oe)
      sram[bus.ram_addr[5:0]] = bus.ram_wdata;
    cyc++;
    if (!rst) begin
      busy      = 1'b0;
      exp_inst  = '0;
      exp_mrd   = '0;
      end_fetch = -100;
      end_data  = -100;
    end else if (busy) begin
      if (cyc == acc_end) begin
        busy = 1'b0;
        if (acc_kind == K_FETCH) begin
          end_fetch = cyc;
          exp_inst  = ref_mem[acc_addr[5:0]];
        end else begin
          end_data = cyc;
          if (acc_kind == K_READ) exp_mrd = ref_mem[acc_addr[5:0]];
        end
      end
    end else begin
      if (bus.mem_we && cyc != end_data + 1) begin
        busy = 1'b1; acc_s = cyc; acc_kind = K_WRITE; acc_end = cyc + 3 + WRC;
        acc_addr = bus.mem_addr; acc_data = bus.mem_wdata;
        ref_mem[acc_addr[5:0]] = acc_data;
      end else if (bus.mem_re && cyc != end_data + 1) begin
        busy = 1'b1; acc_s = cyc; acc_kind = K_READ; acc_end = cyc + 2;
        acc_addr = bus.mem_addr;
      end else if (bus.if_req && cyc != end_fetch + 1) begin
        busy = 1'b1; acc_s = cyc; acc_kind = K_FETCH; acc_end = cyc + 2;
        acc_addr = bus.if_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare();
    bit rd_on, wr_on, we_on, exp_valid, exp_done, exp_stall;
    rd_on = busy && acc_kind != K_WRITE && cyc == acc_s + 1;
    wr_on = busy && acc_kind == K_WRITE && cyc >= acc_s + 1 && cyc <= acc_s + 2 + WRC;
    we_on = busy && acc_kind == K_WRITE && cyc >= acc_s + 2 && cyc <= acc_s + 1 + WRC;
    exp_valid = (cyc == end_fetch);
    exp_done  = (cyc == end_data);
    exp_stall = rst && (((bus.mem_re || bus.mem_we) && !exp_done) || (bus.if_req && !exp_valid));
    chk("ce_n", bus.ram_ce_n, !(rd_on || wr_on));
    chk("oe_n", bus.ram_oe_n, !rd_on);
    chk("we_n", bus.ram_we_n, !we_on);
    chk("data_oe", bus.ram_data_oe, wr_on);
    chk("inst_valid", bus.inst_valid, exp_valid);
    chk("mem_done", bus.mem_done, exp_done);
    chk("inst", bus.inst, exp_inst);
    chk("mem_rdata", bus.mem_rdata, exp_mrd);
    chk("stall_req", bus.stall_req, exp_stall);
    if (rd_on || wr_on) chk("ram_addr", bus.ram_addr, acc_addr[ADDR_W-1:0]);
    if (wr_on) chk("ram_wdata", bus.ram_wdata, acc_data);
  endtask

  task automatic start_fetch(input logic [31:0] a);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    f_st = 1;
  endtask

  task automatic start_mem(input bit re, input bit we, input logic [31:0] a, input logic [31:0] d);
    bus.mem_re    = re;
    bus.mem_we    = we;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    d_st = 1;
  endtask

  task automatic drive();
    if (f_st == 2) begin
      f_st = 0; bus.if_req = 1'b0;
    end else if (f_st == 1 && cyc == end_fetch) begin
      if (force_hold || (rnd && $urandom_range(1) == 1)) f_st = 2;
      else begin f_st = 0; bus.if_req = 1'b0; end
    end else if (f_st == 0 && rnd && $urandom_range(3) == 0) begin
      start_fetch($urandom);
    end
    if (f_st == 1 && scramble && $urandom_range(1) == 1) bus.if_addr = $urandom;

    if (d_st == 2) begin
      d_st = 0; bus.mem_re = 1'b0; bus.mem_we = 1'b0;
    end else if (d_st == 1 && cyc == end_data) begin
      if (force_hold || (rnd && $urandom_range(1) == 1)) d_st = 2;
      else begin d_st = 0; bus.mem_re = 1'b0; bus.mem_we = 1'b0; end
    end else if (d_st == 0 && rnd && $urandom_range(3) == 0) begin
      case ($urandom_range(2))
        0:       start_mem(1'b1, 1'b0, $urandom, $urandom);
        1:       start_mem(1'b0, 1'b1, $urandom, $urandom);
        default: start_mem(1'b1, 1'b1, $urandom, $urandom);
      endcase
    end
    if (d_st == 1 && scramble && $urandom_range(1) == 1) begin
      bus.mem_addr  = $urandom;
      bus.mem_wdata = $urandom;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    drive();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((f_st != 0 || d_st != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", (n < 200), 1'b1);
    step();
    step();
  endtask

  initial begin
    int dn, lo;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_re = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (3) step();
    chk("reset_ce_n", bus.ram_ce_n, 1'b1);
    chk("reset_we_n", bus.ram_we_n, 1'b1);
    chk("reset_inst", bus.inst, 32'h0);
    rst = 1'b1;
    step();

    // Fetch of word 0x10 after reset
    start_fetch(32'h10);
    step(); chk("t1_oe_pre", bus.ram_oe_n, 1'b1);
    step(); chk("t1_oe_low", bus.ram_oe_n, 1'b0);
    step(); chk("t1_valid", bus.inst_valid, 1'b1);
    chk("t1_inst", bus.inst, 32'h3C01_8000);
    chk("t1_stall", bus.stall_req, 1'b0);
    step(); chk("t1_valid_once", bus.inst_valid, 1'b0);
    wait_idle();

    // Write 0x20 then read it back
    start_mem(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    step();
    step(); chk("t2_setup_we", bus.ram_we_n, 1'b1); chk("t2_setup_oe", bus.ram_data_oe, 1'b1);
    for (int i = 0; i < WRC; i++) begin
      step(); chk("t2_pulse_we", bus.ram_we_n, 1'b0);
    end
    step(); chk("t2_hold_we", bus.ram_we_n, 1'b1); chk("t2_hold_oe", bus.ram_data_oe, 1'b1);
    step(); chk("t2_done", bus.mem_done, 1'b1);
    wait_idle();
    start_mem(1'b1, 1'b0, 32'h20, 32'h0);
    step(); step(); step();
    chk("t2_rd_done", bus.mem_done, 1'b1);
    chk("t2_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    wait_idle();

    // Simultaneous fetch and data read: data first, fetch accepted in the done cycle
    start_fetch(32'h5);
    start_mem(1'b1, 1'b0, 32'h6, 32'h0);
    step(); step();
    step(); chk("t3_done", bus.mem_done, 1'b1); chk("t3_rdata", bus.mem_rdata, 32'h2222_0006);
    chk("t3_valid_early", bus.inst_valid, 1'b0);
    step();
    step(); chk("t3_fetch_oe", bus.ram_oe_n, 1'b0);
    step(); chk("t3_valid", bus.inst_valid, 1'b1); chk("t3_inst", bus.inst, 32'h1111_0005);
    wait_idle();

    // Read and write together: write only
    start_mem(1'b1, 1'b1, 32'h30, 32'h1234);
    dn = 0; lo = 0;
    for (int i = 0; i < 3 + WRC + 4; i++) begin
      step();
      if (bus.mem_done) dn++;
      if (!bus.ram_oe_n) lo++;
    end
    chk("t4_done_count", dn, 1);
    chk("t4_no_read", lo, 0);
    wait_idle();
    start_mem(1'b1, 1'b0, 32'h30, 32'h0);
    step(); step(); step();
    chk("t4_rdata", bus.mem_rdata, 32'h1234);
    wait_idle();

    // Request held one cycle past its completion
    force_hold = 1'b1;
    start_mem(1'b1, 1'b0, 32'h10, 32'h0);
    dn = 0; lo = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.mem_done) dn++;
      if (!bus.ram_ce_n) lo++;
    end
    force_hold = 1'b0;
    chk("t5_done_count", dn, 1);
    chk("t5_ce_cycles", lo, 1);
    wait_idle();

    // Reset in the middle of the write pulse
    start_mem(1'b0, 1'b1, 32'h21, 32'hCAFE_F00D);
    step(); step(); step();
    chk("t6_we_low", bus.ram_we_n, 1'b0);
    rst = 1'b0;
    bus.if_req = 1'b0; bus.mem_re = 1'b0; bus.mem_we = 1'b0;
    f_st = 0; d_st = 0;
    step();
    chk("t6_we_n", bus.ram_we_n, 1'b1);
    chk("t6_data_oe", bus.ram_data_oe, 1'b0);
    chk("t6_ce_n", bus.ram_ce_n, 1'b1);
    chk("t6_done", bus.mem_done, 1'b0);
    chk("t6_inst", bus.inst, 32'h0);
    chk("t6_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.mem_done) dn++;
    end
    chk("t6_no_done", dn, 0);

    // Randomized traffic
    rnd = 1'b1;
    scramble = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram2_ctrl.md
# ram2_ctrl

Single-port arbiter and SRAM sequencer for the RAM2 memory. It merges the instruction-fetch port and the MEM-stage data port into one external word-SRAM interface and generates the multi-cycle chip-enable, output-enable and write-enable sequences. It raises a pipeline stall until each accepted access completes. The pipeline sits upstream of this block, and the RAM2 device (real SRAM or the simulation model) sits downstream.

## Interface
- `ADDR_W`, default 18: SRAM word-address width.
- `DATA_W`, default 32: data and instruction width.
- `WR_CYCLES`, default 1: width of the we_n low pulse in clocks, must be ≥1.

- `clk`  in  1  sole clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `if_req_i`  in  1  fetch request, held until `inst_valid_o`.
- `if_addr_i`  in  32  fetch word address.
- `inst_o`  out  DATA_W  fetched instruction, registered.
- `inst_valid_o`  out  1  one-cycle pulse, `inst_o` valid.
- `mem_re_i` / `mem_we_i`  in  1  data read / write request, held until `mem_done_o`.
- `mem_addr_i`  in  32  data word address.
- `mem_data_i`  in  DATA_W  write data.
- `mem_data_o`  out  DATA_W  read data, registered.
- `mem_done_o`  out  1  one-cycle pulse, data access complete.
- `stall_req_o`  out  1  pipeline stall request.
- `ram_addr_o`  out  ADDR_W  SRAM address.
- `ram_data_o`  out  DATA_W  SRAM write data.
- `ram_data_i`  in  DATA_W  SRAM read data.
- `ram_data_oe_o`  out  1  drive enable for the SRAM data bus.
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o`  out  1  SRAM strobes, active-low.

## Operation
- FSM states: IDLE, RD_I, RD_D, WR_SETUP, WR_PULSE, WR_HOLD.
- **Arbitration in IDLE.** Priority order: `mem_we_i` → WR_SETUP, then `mem_re_i` → RD_D, then `if_req_i` → RD_I.
  - If `mem_re_i` and `mem_we_i` are both high, the write wins and no read is performed for that request.
  - A data request is ignored in any cycle where `mem_done_o`=1. This prevents re-accepting a request that is still held high during its completion cycle.
  - A fetch request is ignored in any cycle where `inst_valid_o`=1, for the same reason.
  - In a `mem_done_o` cycle, a pending fetch may be accepted.
- **Latching.** On acceptance, the address (low ADDR_W bits) and write data are latched. Upstream changes after acceptance have no effect on the access.
- **RD_I / RD_D** (1 cycle):
  - Strobes: ce_n=0, oe_n=0, we_n=1, data_oe=0.
  - At the end of the cycle, `ram_data_i` is captured into `inst_o` or `mem_data_o`.
  - The matching valid/done pulse is high in the next cycle. Next state: IDLE.
- **WR_SETUP** (1 cycle): ce_n=0, we_n=1, oe_n=1, data_oe=1.
- **WR_PULSE** (WR_CYCLES cycles): we_n=0, counted by an internal down-counter.
- **WR_HOLD** (1 cycle):
  - we_n=1, data_oe=1; address and data are held.
  - `mem_done_o` pulses in the next cycle. Next state: IDLE.
- **IDLE strobes:** ce_n=oe_n=we_n=1, data_oe=0.
- **`stall_req_o`** (combinational) = `((mem_re_i|mem_we_i) & ~mem_done_o) | (if_req_i & ~inst_valid_o)`. It is forced to 0 while `rst`=0.
- **Unchanged outputs.** `inst_o` and `mem_data_o` hold their last value until the next capture.

## Timing
- Read: request first seen in IDLE at edge k. RD state runs during cycle k+1. Data and pulse appear from edge k+2. Latency is 2 clocks.
- Write: `mem_done_o` is high 3+WR_CYCLES clocks after the accepting edge. With the default `WR_CYCLES`=1, that is 4 clocks.
- Back-to-back accesses: at most one access is in flight. An IDLE cycle always separates consecutive accesses.
- Reset (`rst`=0 at an edge), taking effect at that edge, including mid-access:
  - State becomes IDLE, all strobes are inactive, data_oe=0.
  - `inst_o`, `mem_data_o`, `inst_valid_o` and `mem_done_o` are cleared to 0.
  - The in-flight access is dropped. we_n must never remain low after reset.
- No strobe glitches: all `ram_*` outputs are decoded from registered state and registered latches only.

## Structure
- Shared in `defines.v`:
  - state encodings (3-bit, `Ram2Idle` … `Ram2WrHold`);
  - strobe-level constants `RamChipEnable` and `WriteEnable`;
  - existing `DataBus`, `InstBus` and `DataAddrBus` widths.
- No sub-module is needed. The FSM, latches and WR_CYCLES counter fit in one module.

## Test plan
- After reset, fetch `if_addr_i`=0x10 with the SRAM model holding 0x3C01_8000 at word 0x10 → `ram_oe_n_o` low exactly in cycle k+1, `inst_o`=0x3C018000 with `inst_valid_o` high for one cycle at k+2, and `stall_req_o` low from k+2 onward.
- `mem_we_i` with addr 0x20, data 0xDEAD_BEEF → WR_SETUP, then `ram_we_n_o` low for WR_CYCLES cycles, then WR_HOLD. A following `mem_re_i` at 0x20 returns 0xDEADBEEF.
- `if_req_i` and `mem_re_i` asserted in the same cycle → data read served first. `mem_done_o` pulse, then the fetch is accepted in that same IDLE cycle. `inst_valid_o` follows 2 clocks later.
- `mem_re_i` and `mem_we_i` asserted together, addr 0x30, data 0x1234 → write only. Exactly one `mem_done_o`, and no RD_D state occurs.
- Request held high across its `mem_done_o` cycle, dropped one cycle later → exactly one access performed, with no duplicate strobes.
- `rst`=0 asserted during WR_PULSE, with WR_CYCLES=3 → at the next edge `ram_we_n_o`=1, data_oe=0, state IDLE and all outputs 0. No `mem_done_o` pulse is issued.
